gray_updown_counter: RTL
========================

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 Parameter DATA_WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  load request; takes priority over en.
REQ-008 load_gray  input  DATA_WIDTH  Gray-coded value to load.
REQ-009 gray_out  output  DATA_WIDTH  registered Gray-coded count.
REQ-010 bin_out  output  DATA_WIDTH  binary equivalent of gray_out, from the same internal state.
REQ-011 at_max  output  1  high while the count is all-ones binary (Gray 1 followed by zeros).
REQ-012 at_min  output  1  high while the count is zero.
REQ-013 wrap  output  1  registered one-cycle pulse following a boundary wrap.

Function
REQ-014 Internal state SHALL be a binary register bin_q; gray_out SHALL equal bin_q ^ (bin_q >> 1), registered, with no combinational path from inputs.
REQ-015 Per cycle, in priority order: load=1 -> bin_q <= gray2bin(load_gray); else en=1 -> step; else hold.
REQ-016 A step SHALL be bin_q+1 when up=1 and bin_q-1 when up=0, computed modulo 2^DATA_WIDTH.
REQ-017 SATURATE=0: up at all-ones SHALL go to 0, and down at 0 SHALL go to all-ones; either case SHALL assert wrap on the following cycle only.
REQ-018 SATURATE=1: up at all-ones and down at 0 SHALL hold the count; wrap SHALL stay 0.
REQ-019 Every enabled non-saturated step SHALL change exactly one gray_out bit, including the wrap step.
REQ-020 A load SHALL never assert wrap; loading the current value SHALL leave the outputs unchanged.
REQ-021 at_max and at_min SHALL be decoded from bin_q only and SHALL be independent of en, up and load.
REQ-022 Toggling up between cycles SHALL be legal; every cycle SHALL use the up value sampled in that cycle.
REQ-023 Latency: input to gray_out/bin_out/wrap SHALL be exactly 1 cycle.

Reset
REQ-024 While resetn=0 at a clock edge: bin_q=0, gray_out=0, bin_out=0, wrap=0, at_min=1, at_max=0; reset SHALL override load and en.
REQ-025 Reset asserted mid-count SHALL discard any pending step or wrap pulse; the first step after release SHALL start from 0.

Structure
REQ-026 A shared package SHALL hold the default width constant and the SATURATE mode encodings (WRAP_MODE=0, SAT_MODE=1).
REQ-027 A combinational sub-module gray2bin (parametrised DATA_WIDTH, prefix-XOR) SHALL be used for the load path and SHALL be instantiated once.
REQ-028 Formal properties SHALL assert REQ-019 (one-hot gray delta per step), REQ-018 (hold at the boundary) and REQ-020 (no wrap on load), and SHALL cover one wrap in each direction.

Verification (DATA_WIDTH=4)
REQ-029 Reset, then up=1 en=1 for 16 cycles: gray_out = 0000,0001,0011,0010,0110,...,1000, then 0000; wrap=1 only in the cycle after 1000->0000.
REQ-030 Reset, then up=0 en=1 for 1 cycle: gray_out=1000, bin_out=1111, at_max=1, wrap=1 for exactly one cycle.
REQ-031 load=1 with load_gray=0110 and en=1 in the same cycle: next bin_out=0100 and gray_out=0110, no wrap; then one step down gives gray_out=0010.
REQ-032 SATURATE=1: count up to 1000, then keep en=1 up=1 for 5 cycles: gray_out stays 1000, at_max=1, wrap=0; then up=0 gives 1001 (binary 14).
REQ-033 With the count at binary 9 and en=1, drive resetn=0 for one cycle: next gray_out=0000, wrap=0; after release the count steps to 0001.
REQ-034 Random en/up/load for 10k cycles with SATURATE 0 and 1: scoreboard the binary model; gray_out Hamming distance per enabled non-load, non-saturated step is 1.

Source files
------------

// File: rtl/gray_updown_counter_pkg.sv
// rtl/gray_updown_counter_pkg.sv - shared constants and helpers for the Gray up/down counter
package gray_updown_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Boundary behaviour encodings for the SATURATE parameter
    localparam int WRAP_MODE = 0;
    localparam int SAT_MODE  = 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// rtl/gray_updown_counter_if.sv - control and status bundle for the Gray up/down counter
interface gray_updown_counter_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_gray;
    logic [DATA_WIDTH-1:0] gray_out;
    logic [DATA_WIDTH-1:0] bin_out;
    logic                  at_max;
    logic                  at_min;
    logic                  wrap;

    modport master (
        output en, up, load, load_gray,
        input  gray_out, bin_out, at_max, at_min, wrap
    );

    modport slave (
        input  en, up, load, load_gray,
        output gray_out, bin_out, at_max, at_min, wrap
    );
endinterface

// File: rtl/gray_updown_counter_gray2bin.sv
// rtl/gray_updown_counter_gray2bin.sv - combinational Gray to binary converter (prefix XOR from MSB)
module gray2bin #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray_i,
    output logic [DATA_WIDTH-1:0] bin_o
);
    always_comb begin
        bin_o = gray_i;
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end
endmodule

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - binary-state up/down counter with registered Gray output
module gray_updown_counter
    import gray_updown_counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_WIDTH,
    parameter int SATURATE   = WRAP_MODE
) (
    input  logic clk,
    input  logic resetn,
    gray_updown_counter_if.slave cnt
);
    localparam logic                  SAT_EN = (SATURATE == SAT_MODE);
    localparam logic [DATA_WIDTH-1:0] ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] gray_q, gray_d;
    logic [DATA_WIDTH-1:0] load_bin;
    logic                  wrap_q, wrap_d;
    logic                  at_max_w, at_min_w, sat_hold;

    gray2bin #(.DATA_WIDTH(DATA_WIDTH)) u_gray2bin (
        .gray_i (cnt.load_gray),
        .bin_o  (load_bin)
    );

    assign at_max_w = &bin_q;
    assign at_min_w = ~|bin_q;
    // A step that would cross the boundary is suppressed in saturating mode
    assign sat_hold = SAT_EN && (cnt.up ? at_max_w : at_min_w);

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (cnt.load) begin
            bin_d = load_bin;
        end else if (cnt.en && !sat_hold) begin
            if (cnt.up) begin
                bin_d  = bin_q + ONE;
                wrap_d = at_max_w;
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = at_min_w;
            end
        end
        gray_d = DATA_WIDTH'(bin2gray(32'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt.gray_out = gray_q;
    assign cnt.bin_out  = bin_q;
    assign cnt.at_max   = at_max_w;
    assign cnt.at_min   = at_min_w;
    assign cnt.wrap     = wrap_q;

    a_gray_onehot_step: assert property (@(posedge clk) disable iff (!resetn)
        (cnt.en && !cnt.load && !sat_hold) |=> $onehot(gray_q ^ $past(gray_q)));
    a_sat_hold: assert property (@(posedge clk) disable iff (!resetn)
        (cnt.en && !cnt.load && sat_hold) |=> ($stable(bin_q) && !wrap_q));
    a_no_wrap_on_load: assert property (@(posedge clk) disable iff (!resetn)
        cnt.load |=> !wrap_q);
    c_wrap_up: cover property (@(posedge clk) disable iff (!resetn)
        cnt.en && !cnt.load && cnt.up && at_max_w && !SAT_EN);
    c_wrap_down: cover property (@(posedge clk) disable iff (!resetn)
        cnt.en && !cnt.load && !cnt.up && at_min_w && !SAT_EN);
endmodule
